// File: rtl/axis_word_fifo.sv
// Word FIFO with an AXI-Stream master read side and a strobed write side.
// Optional feature: define AXIS_WORD_FIFO_OVF_CNT_EN to add a saturating overflow counter (ovf_cnt).
module axis_word_fifo #(
  parameter int T_DATA_W = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [8*T_DATA_W-1:0]    data_word,
  input  logic                     w_en,
  output logic                     full,
  output logic                     almost_full,
  output logic [8*T_DATA_W-1:0]    M_TDATA,
  output logic                     M_TVALID,
  input  logic                     M_TREADY,
  output logic [$clog2(DEPTH):0]   count
`ifdef AXIS_WORD_FIFO_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 8 * T_DATA_W;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Status comes only from the registered count, so no input reaches these outputs combinationally.
  assign w_full  = (r_count == FULL_LVL);
  assign w_empty = (r_count == '0);
  assign w_push  = w_en & ~w_full;
  assign w_pop   = ~w_empty & M_TREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage is not reset; an empty count masks stale contents.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= data_word;
  end

  assign full        = w_full;
  assign almost_full = (r_count >= AF_LVL);
  assign count       = r_count;
  assign M_TVALID    = ~w_empty;
  assign M_TDATA     = w_empty ? '0 : r_mem[r_rd_ptr];

`ifdef AXIS_WORD_FIFO_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ovf_cnt <= '0;
    end else if (w_en && w_full && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: doc/axis_word_fifo.md
AXIS_WORD_FIFO -- requirements
Module: axis_word_fifo

Interface
REQ-001 SHALL provide parameter T_DATA_W, default 8, meaning the data word width in bytes (word = 8*T_DATA_W bits).
REQ-002 SHALL provide parameter DEPTH, default 16, meaning the number of storage entries; legal values are powers of two, 4 or greater.
REQ-003 SHALL provide parameter AF_LEVEL, default 14, meaning the occupancy at or above which almost_full asserts.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL provide port ACLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 SHALL provide port ARESET, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL provide port data_word, input, 8*T_DATA_W bits: write data.
REQ-008 SHALL provide port w_en, input, 1 bit: single-cycle write strobe.
REQ-009 SHALL provide port full, output, 1 bit: occupancy equals DEPTH.
REQ-010 SHALL provide port almost_full, output, 1 bit: occupancy is at least AF_LEVEL.
REQ-011 SHALL provide port M_TDATA, output, 8*T_DATA_W bits: stream data at the head of the FIFO.
REQ-012 SHALL provide port M_TVALID, output, 1 bit: head entry valid.
REQ-013 SHALL provide port M_TREADY, input, 1 bit: downstream accepts the head entry.
REQ-014 SHALL provide port count, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 SHALL accept a push when w_en=1 and full=0 on a rising edge, storing data_word at wr_ptr and advancing wr_ptr.
REQ-016 SHALL discard w_en when full=1, with no change to pointers, count or stored data.
REQ-017 SHALL perform a pop when M_TVALID=1 and M_TREADY=1 on a rising edge, advancing rd_ptr.
REQ-018 SHALL drive M_TVALID=1 exactly when count is non-zero, and drive M_TDATA with the entry at rd_ptr when count is non-zero and all-zero otherwise.
REQ-019 SHALL present a pushed word on M_TDATA/M_TVALID one cycle after the push edge when the FIFO was empty (latency 1).
REQ-020 SHALL hold M_TDATA stable while M_TVALID=1 and M_TREADY=0.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-022 SHALL, when full and popped with w_en=1 in the same cycle, accept the pop and drop the write, because full is evaluated from pre-edge state.
REQ-023 SHALL, when empty and written with M_TREADY=1 in the same cycle, accept the write and perform no pop.
REQ-024 SHALL wrap wr_ptr and rd_ptr modulo DEPTH (clog2(DEPTH) bits), and SHALL keep count in the range 0..DEPTH.
REQ-025 SHALL drive full, almost_full and count as registered or pointer-derived values with no combinational path from w_en or M_TREADY.
REQ-026 SHALL preserve FIFO order: words leave in exactly the order they were accepted.

Reset
REQ-027 SHALL, while ARESET=1, force wr_ptr=0, rd_ptr=0, count=0, full=0, almost_full=0, M_TVALID=0 and M_TDATA=0, independent of ACLK.
REQ-028 SHALL, on reset mid-operation, discard all stored words; storage contents need not be cleared.
REQ-029 SHALL accept the first push on the first rising edge after ARESET deasserts.

Configuration
REQ-030 SHALL, when macro AXIS_WORD_FIFO_OVF_CNT_EN is defined, add output ovf_cnt (16 bits) that increments once per cycle with w_en=1 and full=1, saturates at 16'hFFFF, and resets to 0 on ARESET.
REQ-031 SHALL, when AXIS_WORD_FIFO_OVF_CNT_EN is not defined, omit the ovf_cnt port and logic, with all other behaviour unchanged.

Verification (T_DATA_W=8, DEPTH=4, AF_LEVEL=3)
REQ-032 Reset then a single push of 64'hA5A5_0000_0000_0001 with M_TREADY=0 -> next cycle M_TVALID=1, M_TDATA equals the pushed word, count=1.
REQ-033 4 pushes of 1,2,3,4 then a 5th push of 5 -> full=1 after the 4th, almost_full=1 after the 3rd, 5th dropped; draining yields 1,2,3,4 only.
REQ-034 Full FIFO, w_en=1 with data 9 and M_TREADY=1 in the same cycle -> 1 popped, 9 dropped, count=3, full=0.
REQ-035 10 consecutive cycles with w_en=1 and M_TREADY=1 from empty -> output sequence matches input, count never exceeds 1, pointers wrap correctly.
REQ-036 3 words stored, ARESET pulsed for 1 cycle -> M_TVALID=0, count=0, full=0 immediately; next push reappears with latency 1.
REQ-037 With AXIS_WORD_FIFO_OVF_CNT_EN defined: full FIFO, 3 cycles of w_en=1 with M_TREADY=0 -> ovf_cnt=3.
